// File: rtl/uart_periph.sv
// uart_periph: memory-mapped 8N1 UART with TX/RX registers, status flags and level IRQ
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   rd/wr  bus read/write strobes
//   addr   bus byte address (window 0x40000018..0x40000020)
//   wdata  bus write data
//   rdata  combinational read data, 0 when not reading this window
//   rx     asynchronous serial input, idle high
//   tx     registered serial output, idle high
//   IRQ    (TX_DONE & TX_IRQ_EN) | (RX_DONE & RX_IRQ_EN)
module uart_periph #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD = 9600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx,
  output logic        IRQ
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] TOP = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_t;
  st_t ts, ts_n, rs, rs_n;
  logic [CW-1:0] tc, tc_n, rc, rc_n;
  logic [2:0] ti, ti_n, ri, ri_n;
  logic [7:0] txd, txd_n, rxd, sh, sh_n;
  logic tx_n, tx_fin, tx_acc, busy;
  logic s1, s2, rp, rx_ok, rx_fe;
  logic ten, ren, rxdone, txdone, fe, ovr;
  logic sel_txd, sel_rxd, sel_con, con_wr, rxd_rd;
  logic unused;
  assign sel_txd = addr == 32'h40000018;
  assign sel_rxd = addr == 32'h4000001C;
  assign sel_con = addr == 32'h40000020;
  assign con_wr = wr & sel_con;
  assign rxd_rd = rd & sel_rxd;
  assign busy = ts != IDLE;
  assign tx_acc = wr & sel_txd & ~busy;
  assign unused = ^wdata[31:8];
  always_comb begin
    ts_n = ts;
    ti_n = ti;
    tx_fin = 1'b0;
    tc_n = (ts == IDLE || tc == TOP) ? '0 : tc + 1'b1;
    txd_n = tx_acc ? wdata[7:0] : txd;
    case (ts)
      IDLE:  if (tx_acc) ts_n = START;
      START: if (tc == TOP) begin
        ts_n = DATA;
        ti_n = '0;
      end
      DATA:  if (tc == TOP) begin
        ti_n = ti + 1'b1;
        if (ti == 3'd7) ts_n = STOP;
      end
      STOP:  if (tc == TOP) begin
        ts_n = IDLE;
        tx_fin = 1'b1;
      end
      default: ts_n = IDLE;
    endcase
    // tx is registered, so it follows the bit selected by the next state
    tx_n = ts_n == START ? 1'b0 : ts_n == DATA ? txd_n[ti_n] : 1'b1;
  end
  // rx counter counts down; sampling happens when it reaches zero,
  // first at mid start bit, then every DIV cycles
  always_comb begin
    rs_n = rs;
    ri_n = ri;
    sh_n = sh;
    rx_ok = 1'b0;
    rx_fe = 1'b0;
    rc_n = rc == '0 ? TOP : rc - 1'b1;
    case (rs)
      IDLE: begin
        rc_n = HALF;
        if (rp & ~s2) rs_n = START;
      end
      START: if (rc == '0) begin
        rs_n = s2 ? IDLE : DATA;
        ri_n = '0;
      end
      DATA: if (rc == '0) begin
        sh_n = {s2, sh[7:1]};
        ri_n = ri + 1'b1;
        if (ri == 3'd7) rs_n = STOP;
      end
      STOP: if (rc == '0) begin
        rs_n = IDLE;
        rx_ok = s2;
        rx_fe = ~s2;
      end
      default: rs_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts <= IDLE;
      tc <= '0;
      ti <= '0;
      txd <= '0;
      tx <= 1'b1;
      rs <= IDLE;
      rc <= '0;
      ri <= '0;
      sh <= '0;
      rxd <= '0;
      s1 <= 1'b1;
      s2 <= 1'b1;
      rp <= 1'b1;
      ten <= 1'b0;
      ren <= 1'b0;
      rxdone <= 1'b0;
      txdone <= 1'b0;
      fe <= 1'b0;
      ovr <= 1'b0;
    end else begin
      ts <= ts_n;
      tc <= tc_n;
      ti <= ti_n;
      txd <= txd_n;
      tx <= tx_n;
      rs <= rs_n;
      rc <= rc_n;
      ri <= ri_n;
      sh <= sh_n;
      s1 <= rx;
      s2 <= s1;
      rp <= s2;
      if (rx_ok) rxd <= sh;
      if (con_wr) begin
        ten <= wdata[0];
        ren <= wdata[1];
      end
      // flags: a completion event beats a simultaneous clear
      rxdone <= rx_ok | (rxdone & (~con_wr | wdata[2]) & ~rxd_rd);
      txdone <= tx_fin | (txdone & (~con_wr | wdata[3]));
      fe <= rx_fe | (fe & (~con_wr | wdata[5]));
      ovr <= (rx_ok & rxdone) | (ovr & (~con_wr | wdata[6]));
    end
  end
  assign rdata = !rd ? 32'h0 :
                 sel_txd ? {24'h0, txd} :
                 sel_rxd ? {24'h0, rxd} :
                 sel_con ? {25'h0, ovr, fe, busy, txdone, rxdone, ren, ten} : 32'h0;
  assign IRQ = (txdone & ten) | (rxdone & ren);
endmodule
